ttl_latch_strobe_arb: RTL

TTL_LATCH_STROBE_ARB -- requirements
Module: ttl_latch_strobe_arb

---
 rtl/ttl_sync_pkg.sv | 18 +
 rtl/ttl_rr_arb.sv | 29 ++
 rtl/ttl_latch_strobe_arb.sv | 94 +++++++++
 3 files changed

// File: rtl/ttl_sync_pkg.sv
// Shared types and default timing for the TTL latch strobe arbiter.
// Phase lengths are counted in clock cycles by a 4-bit down-counter.
package ttl_sync_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  localparam int PHASE_W        = 4;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;

endpackage

// File: rtl/ttl_rr_arb.sv
// Combinational round-robin picker: first requesting port at or after Pointer,
// wrapping modulo PORTS.
module ttl_rr_arb #(
  parameter int PORTS = 4,
  parameter int IDW   = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] Req,
  input  logic [IDW-1:0]   Pointer,
  output logic             grant_valid,
  output logic [IDW-1:0]   grant_id
);

  logic [IDW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      idx = IDW'((int'(Pointer) + i) % PORTS);
      if (Req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/ttl_latch_strobe_arb.sv
// Arbitrates PORTS writers onto one shared data bus and strobes the granted
// port's latch enable with programmable setup / strobe / hold phases.
module ttl_latch_strobe_arb
  import ttl_sync_pkg::*;
#(
  parameter int BLOCKS     = 8,
  parameter int PORTS      = 4,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int IDW        = $clog2(PORTS)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [PORTS-1:0]        Req,
  input  logic [PORTS*BLOCKS-1:0] D_in,
  output logic [PORTS-1:0]        Ack,
  output logic [BLOCKS-1:0]       D_out,
  output logic [PORTS-1:0]        Cen,
  output logic                    Busy,
  output logic [IDW-1:0]          Grant_id,
  output state_t                  Dbg_state
);

  // Handshake: Req[p] is a level held by the requester until it sees the
  // one-cycle Ack[p] pulse; the transaction completes even if Req drops early.

  state_t               state, state_nx;
  logic [PHASE_W-1:0]   phase, phase_nx;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       arb_id;
  logic                 arb_valid;
  logic [PORTS-1:0]     port_sel;

  ttl_rr_arb #(.PORTS(PORTS), .IDW(IDW)) u_rr_arb (
    .Req         (Req),
    .Pointer     (ptr),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  assign port_sel  = PORTS'(1) << Grant_id;
  assign Busy      = (state != S_IDLE);
  assign Dbg_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (arb_valid) state_nx = S_SETUP;
      S_SETUP:  if (phase == '0) state_nx = S_STROBE;
      S_STROBE: if (phase == '0) state_nx = S_HOLD;
      S_HOLD:   if (phase == '0) state_nx = S_ACK;
      S_ACK:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase

    // Saturating count-down; reloaded with the phase length on every entry.
    phase_nx = (phase == '0) ? '0 : phase - PHASE_W'(1);
    if (state_nx != state) begin
      case (state_nx)
        S_SETUP:  phase_nx = PHASE_W'(SETUP_CYC - 1);
        S_STROBE: phase_nx = PHASE_W'(STROBE_CYC - 1);
        S_HOLD:   phase_nx = PHASE_W'(HOLD_CYC - 1);
        default:  phase_nx = '0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= S_IDLE;
      phase    <= '0;
      ptr      <= '0;
      Grant_id <= '0;
      D_out    <= '0;
      Cen      <= '0;
      Ack      <= '0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      if (state == S_IDLE && arb_valid) begin
        Grant_id <= arb_id;
        D_out    <= D_in[int'(arb_id)*BLOCKS +: BLOCKS];
        ptr      <= (arb_id == IDW'(PORTS - 1)) ? '0 : arb_id + IDW'(1);
      end else if (state == S_ACK) begin
        Grant_id <= '0;
      end
      // Enables and acks are registered so the latch clocks are glitch-free.
      Cen <= (state_nx == S_STROBE) ? port_sel : '0;
      Ack <= (state_nx == S_ACK)    ? port_sel : '0;
    end
  end

endmodule
